// File: rtl/timetag_pkg.sv
// Shared definitions for the time-tag record path.
// Holds the record/word geometry produced by the event tagger and consumed
// by the record serializer, plus the serializer state encoding.
package timetag_pkg;

   localparam int REC_W         = 47;  // tagger record width
   localparam int WORD_W        = 48;  // stored word: {lost_flag, record}
   localparam int BYTES_PER_REC = 6;   // WORD_W / 8
   localparam int LOST_W        = 16;  // saturating lost-record counter width

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/record_fifo.sv
// First-word-fall-through FIFO for serializer words.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear         - synchronous clear (empties the FIFO)
//   wr_en/wr_data - push one word
//   rd_en         - pop the word currently presented on rd_data
//   rd_data       - head word (valid whenever !empty)
//   full, empty   - derived from the registered level
//   level         - number of stored words, 0 .. 2**DEPTH_LOG2
module record_fifo #(
   parameter int WIDTH      = 48,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q;
   logic [DEPTH_LOG2:0] rd_ptr_q;
   logic [DEPTH_LOG2:0] level_q;

   // Storage needs no reset; only pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !clear) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (wr_en && !rd_en) begin
            level_q <= level_q + PTR_ONE;
         end else if (!wr_en && rd_en) begin
            level_q <= level_q - PTR_ONE;
         end
      end
   end

   // Pointers carry one extra bit; the low bits index the circular storage.
   assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
   assign full    = (level_q == FULL_LEVEL);
   assign empty   = (level_q == '0);
   assign level   = level_q;

endmodule

// File: rtl/record_serializer.sv
// Buffers 47-bit tagger records and streams them to the host as bytes,
// MSB byte first, six bytes per record. Records arriving while the buffer
// is full are dropped; the next accepted record carries a lost flag in
// bit 7 of its first byte, and a saturating lost counter plus a sticky
// overflow bit are kept for register readout.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   data_rdy, data      - one-cycle record strobe and record from the tagger
//   enable              - gates new writes only; buffered records still drain
//   flush               - synchronous clear of FIFO, serializer and lost state
//   out_data, out_valid - byte stream toward the host
//   out_ready           - host accepts a byte when out_valid & out_ready
//   fifo_level          - records stored in the FIFO
//   lost_count          - saturating count of dropped records
//   overflow            - sticky, set on the first drop
// Handshake: a byte transfers on a rising edge where out_valid & out_ready;
// while out_valid & !out_ready, out_data and out_valid are held unchanged.
module record_serializer
   import timetag_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int REC_W      = timetag_pkg::REC_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  data_rdy,
   input  logic [REC_W-1:0]      data,
   input  logic                  enable,
   input  logic                  flush,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic [LOST_W-1:0]     lost_count,
   output logic                  overflow
);

   localparam int                WW       = REC_W + 1;
   localparam logic [2:0]        LAST_IDX = 3'(BYTES_PER_REC - 1);
   localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};
   localparam logic [LOST_W-1:0] LOST_ONE = {{(LOST_W-1){1'b0}}, 1'b1};

   ser_state_e        state_q;
   logic [WW-1:0]     word_q;
   logic [2:0]        byte_idx_q;
   logic              out_valid_q;
   logic              pending_lost_q;
   logic [LOST_W-1:0] lost_count_q;
   logic              overflow_q;

   logic [WW-1:0]     fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              last_byte;
   logic              pop;
   logic              strobe;
   logic              wr_en;
   logic              drop;

   assign accept    = out_valid_q & out_ready;
   assign last_byte = (byte_idx_q == LAST_IDX);

   // Pop either to start from IDLE or to chain the next word straight after
   // the final byte of the current one, so back-to-back records have no gap.
   assign pop = !flush && !fifo_empty &&
                ((state_q == IDLE) || (state_q == SEND && accept && last_byte));

   // A same-cycle pop frees a slot, so a write into a full FIFO can still land.
   assign strobe = data_rdy & enable & !flush;
   assign wr_en  = strobe & (!fifo_full | pop);
   assign drop   = strobe & fifo_full & !pop;

   record_fifo #(
      .WIDTH      (WW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .wr_en   (wr_en),
      .wr_data ({pending_lost_q, data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Serializer: word_q shifts left one byte per accepted byte, so the byte
   // on the wire is always word_q's top byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         byte_idx_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= IDLE;
         word_q      <= '0;
         byte_idx_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  word_q      <= fifo_rd_data;
                  byte_idx_q  <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  if (!last_byte) begin
                     word_q     <= {word_q[WW-9:0], 8'h00};
                     byte_idx_q <= byte_idx_q + 3'd1;
                  end else if (pop) begin
                     word_q     <= fifo_rd_data;
                     byte_idx_q <= '0;
                  end else begin
                     out_valid_q <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Lost-record bookkeeping; a flag raised by a drop rides on the next
   // accepted record and is then cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_lost_q <= 1'b0;
         lost_count_q   <= '0;
         overflow_q     <= 1'b0;
      end else if (flush) begin
         pending_lost_q <= 1'b0;
         lost_count_q   <= '0;
         overflow_q     <= 1'b0;
      end else if (wr_en) begin
         pending_lost_q <= 1'b0;
      end else if (drop) begin
         pending_lost_q <= 1'b1;
         overflow_q     <= 1'b1;
         if (lost_count_q != LOST_MAX) begin
            lost_count_q <= lost_count_q + LOST_ONE;
         end
      end
   end

   assign out_data   = word_q[WW-1 -: 8];
   assign out_valid  = out_valid_q;
   assign lost_count = lost_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_record_serializer.sv
// Bench for record_serializer: directed scenarios plus randomized traffic,
// checked every cycle against a record-queue reference model.
module tb_record_serializer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        data_rdy;
   logic [46:0] data;
   logic        enable;
   logic        flush;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [4:0]  fifo_level;
   logic [15:0] lost_count;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   // Reference model: records waiting in the buffer, bytes still to be sent
   // for the record currently on the wire, and the lost bookkeeping.
   logic [47:0] rec_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  acc_log[$];
   int          m_left    = 0;
   logic        m_pend    = 1'b0;
   logic [15:0] m_lost    = 16'd0;
   logic        m_ovf     = 1'b0;
   logic        hold_q    = 1'b0;
   logic [7:0]  hold_data = 8'd0;
   logic [7:0]  first_byte = 8'd0;

   record_serializer #(
      .DEPTH_LOG2 (4),
      .REC_W      (47)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_rdy   (data_rdy),
      .data       (data),
      .enable     (enable),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .lost_count (lost_count),
      .overflow   (overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      rec_q.delete();
      exp_q.delete();
      m_left = 0;
      m_pend = 1'b0;
      m_lost = 16'd0;
      m_ovf  = 1'b0;
      hold_q = 1'b0;
   endtask

   // ---------------- scoreboard / model ----------------
   // Outputs are sampled at negedge; inputs seen here are the ones the next
   // rising edge will act on.
   always @(negedge clk) begin : model
      logic [47:0] w;
      logic        acc;
      logic        pop;
      logic        full;
      if (!reset_n) begin
         model_clear();
      end else begin
         if (hold_q) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_data", out_data, hold_data);
         end
         check_eq("out_valid", out_valid, m_left != 0);
         if (m_left != 0) check_eq("out_data", out_data, exp_q[0]);
         check_eq("fifo_level", fifo_level, rec_q.size());
         check_eq("lost_count", lost_count, m_lost);
         check_eq("overflow", overflow, m_ovf);
         hold_q    = out_valid && !out_ready && !flush;
         hold_data = out_data;
         if (flush) begin
            model_clear();
         end else begin
            acc  = (m_left != 0) && out_ready;
            pop  = (rec_q.size() > 0) && (m_left == 0 || (acc && m_left == 1));
            full = (rec_q.size() == DEPTH);
            if (acc) begin
               acc_log.push_back(out_data);
               if (m_left == 6) first_byte = out_data;
               void'(exp_q.pop_front());
               m_left--;
            end
            if (pop) begin
               w = rec_q.pop_front();
               for (int b = 0; b < 6; b++) exp_q.push_back(w[47-8*b -: 8]);
               m_left = 6;
            end
            if (data_rdy && enable) begin
               if (!full || pop) begin
                  rec_q.push_back({m_pend, data});
                  m_pend = 1'b0;
               end else begin
                  if (m_lost != 16'hFFFF) m_lost++;
                  m_pend = 1'b1;
                  m_ovf  = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [46:0] d);
      data_rdy = 1'b1;
      data     = d;
      step();
      data_rdy = 1'b0;
   endtask

   function automatic logic [46:0] rand_rec();
      return 47'({$urandom(), $urandom()});
   endfunction

   task automatic wait_idle(input string tag, input int max_cycles);
      int n = 0;
      while ((m_left != 0 || rec_q.size() != 0) && n < max_cycles) begin
         step();
         n++;
      end
      check_eq(tag, n < max_cycles, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [7:0]  exp_bytes [6];
      logic [46:0] rec_a;
      logic [46:0] rec_b;
      int          base;
      logic        found;

      exp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      reset_n   = 1'b0;
      data_rdy  = 1'b0;
      data      = '0;
      enable    = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Reset values
      repeat (3) step();
      check_eq("rst_out_data", out_data, 8'h00);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_fifo_level", fifo_level, 5'd0);
      check_eq("rst_lost_count", lost_count, 16'd0);
      check_eq("rst_overflow", overflow, 1'b0);
      reset_n = 1'b1;
      step();

      // Single record: latency and byte order
      base = acc_log.size();
      strobe(47'h1234_5678_9ABC);
      check_eq("lat_n1_valid", out_valid, 1'b0);
      step();
      check_eq("lat_n2_valid", out_valid, 1'b1);
      check_eq("lat_n2_data", out_data, 8'h12);
      repeat (8) step();
      check_eq("single_count", acc_log.size() - base, 6);
      for (int i = 0; i < 6; i++) check_eq("single_byte", acc_log[base+i], exp_bytes[i]);
      check_eq("single_idle", out_valid, 1'b0);
      check_eq("single_lost", lost_count, 16'd0);

      // Two consecutive strobes: 12 bytes, no gap, order preserved
      base  = acc_log.size();
      rec_a = rand_rec();
      rec_b = rand_rec();
      strobe(rec_a);
      strobe(rec_b);
      repeat (12) step();
      check_eq("pair_count", acc_log.size() - base, 12);
      check_eq("pair_a0", acc_log[base], {1'b0, rec_a[46:40]});
      check_eq("pair_b0", acc_log[base+6], {1'b0, rec_b[46:40]});
      check_eq("pair_b5", acc_log[base+11], rec_b[7:0]);

      // Overflow: 18 strobes with host stalled
      out_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         data_rdy = 1'b1;
         data     = rand_rec();
         step();
      end
      data_rdy = 1'b0;
      check_eq("ovf_lost", lost_count, 16'd1);
      check_eq("ovf_flag", overflow, 1'b1);
      check_eq("ovf_level", fifo_level, 5'd16);
      out_ready = 1'b1;
      wait_idle("ovf_drain_timeout", 300);
      rec_a = rand_rec();
      strobe(rec_a);
      wait_idle("flag_rec_timeout", 40);
      check_eq("lost_flag_set", first_byte, {1'b1, rec_a[46:40]});
      rec_b = rand_rec();
      strobe(rec_b);
      wait_idle("clean_rec_timeout", 40);
      check_eq("lost_flag_clear", first_byte, {1'b0, rec_b[46:40]});

      // Randomized traffic with backpressure, enable gaps and rare flushes
      for (int i = 0; i < 3000; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         data_rdy  = ($urandom_range(0, 3) == 0);
         data      = rand_rec();
         enable    = ($urandom_range(0, 15) != 0);
         flush     = ($urandom_range(0, 199) == 0);
         step();
      end
      data_rdy  = 1'b0;
      flush     = 1'b0;
      enable    = 1'b1;
      out_ready = 1'b1;
      wait_idle("rand_drain_timeout", 300);

      // Saturation of lost_count, then flush
      flush = 1'b1;
      step();
      flush     = 1'b0;
      out_ready = 1'b0;
      data_rdy  = 1'b1;
      for (int i = 0; i < 70020; i++) begin
         data = rand_rec();
         step();
      end
      data_rdy = 1'b0;
      check_eq("sat_lost", lost_count, 16'hFFFF);
      check_eq("sat_ovf", overflow, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("flush_lost", lost_count, 16'd0);
      check_eq("flush_ovf", overflow, 1'b0);
      check_eq("flush_level", fifo_level, 5'd0);
      check_eq("flush_valid", out_valid, 1'b0);

      // enable low: strobes ignored, not counted
      out_ready = 1'b1;
      enable    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         strobe(rand_rec());
         step();
      end
      repeat (3) step();
      check_eq("dis_level", fifo_level, 5'd0);
      check_eq("dis_lost", lost_count, 16'd0);
      check_eq("dis_valid", out_valid, 1'b0);
      enable = 1'b1;

      // Asynchronous reset while byte 3 is on the wire
      strobe(rand_rec());
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_left == 3) found = 1'b1;
         else step();
      end
      check_eq("byte3_reached", found, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check_eq("arst_valid", out_valid, 1'b0);
      check_eq("arst_data", out_data, 8'h00);
      check_eq("arst_level", fifo_level, 5'd0);
      check_eq("arst_lost", lost_count, 16'd0);
      check_eq("arst_ovf", overflow, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (4) step();
      check_eq("post_rst_valid", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
